// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR access controller:
// CSR addresses, Zicsr funct3 encodings, FSM states, mstatus bit positions
// and the read-modify-write operator.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // funct3[1:0] selects the operation; funct3[2] only selects the operand
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // New CSR value for a Zicsr read-modify-write
  function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      OP_RW:   result = operand;
      OP_RS:   result = old_val | operand;
      OP_RC:   result = old_val & ~operand;
      default: result = old_val;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A half write wins over the increment in the same cycle; the count wraps.
module csr_counter64 (
  input  logic        CLK,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  // Count up, or replace one half when software writes it
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= 64'd0;
    end else if (wr_lo) begin
      count <= {count[63:32], wr_data};
    end else if (wr_hi) begin
      count <= {wr_data, count[31:0]};
    end else if (inc_en) begin
      count <= count + 64'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/csr_access_controller.sv
// Machine-mode CSR access controller: sequences Zicsr read-modify-write
// requests (IDLE -> READ -> COMMIT) and performs single-cycle trap entry.
// Optional build macro CSR_COUNTERS_EN adds mcycle/minstret and their
// user read-only aliases; without it those addresses decode as illegal.
module csr_access_controller
  import csr_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            pipe_req_valid,
  output logic            pipe_req_ready,
  input  logic [2:0]      pipe_funct3,
  input  logic [11:0]     pipe_csr_addr,
  input  logic [XLEN-1:0] pipe_rs1,
  input  logic [4:0]      pipe_rs1_field,
  output logic            pipe_rd_valid,
  output logic [XLEN-1:0] pipe_rd,
  output logic            pipe_illegal,
  input  logic            trap_req_valid,
  output logic            trap_req_ready,
  input  logic [XLEN-1:0] trap_mepc,
  input  logic [XLEN-1:0] trap_mcause,
  input  logic            retire,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_out,
  output logic            busy
);

  state_t          state_r;
  logic [1:0]      req_op_r;
  logic [11:0]     req_addr_r;
  logic [XLEN-1:0] req_operand_r;
  logic [4:0]      req_field_r;
  logic [XLEN-1:0] new_r;
  logic            wen_r;

  logic            mie_r;
  logic            mpie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;

  logic [XLEN-1:0] rd_data_s;
  logic            implemented_s;
  logic            write_req_s;
  logic            illegal_s;
  logic [XLEN-1:0] new_s;

  assign trap_req_ready = (state_r == ST_IDLE);
  assign pipe_req_ready = (state_r == ST_IDLE) & ~trap_req_valid;
  assign mtvec_out      = mtvec_r;
  assign mepc_out       = mepc_r;
  assign mie_out        = mie_r;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;
  logic        commit_wr_s;

  assign commit_wr_s = (state_r == ST_COMMIT) & wen_r;

  csr_counter64 u_mcycle (
    .CLK     (CLK),
    .reset   (reset),
    .inc_en  (1'b1),
    .wr_lo   (commit_wr_s & (req_addr_r == ADDR_MCYCLE)),
    .wr_hi   (commit_wr_s & (req_addr_r == ADDR_MCYCLEH)),
    .wr_data (new_r),
    .count   (mcycle_s)
  );

  csr_counter64 u_minstret (
    .CLK     (CLK),
    .reset   (reset),
    .inc_en  (retire),
    .wr_lo   (commit_wr_s & (req_addr_r == ADDR_MINSTRET)),
    .wr_hi   (commit_wr_s & (req_addr_r == ADDR_MINSTRETH)),
    .wr_data (new_r),
    .count   (minstret_s)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Decode the latched address into its current value and check legality
  always_comb begin
    rd_data_s     = {XLEN{1'b0}};
    implemented_s = 1'b1;
    case (req_addr_r)
      ADDR_MSTATUS: begin
        rd_data_s[MSTATUS_MIE]  = mie_r;
        rd_data_s[MSTATUS_MPIE] = mpie_r;
      end
      ADDR_MTVEC:    rd_data_s = mtvec_r;
      ADDR_MSCRATCH: rd_data_s = mscratch_r;
      ADDR_MEPC:     rd_data_s = mepc_r;
      ADDR_MCAUSE:   rd_data_s = mcause_r;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,    ADDR_CYCLE:    rd_data_s = mcycle_s[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   rd_data_s = mcycle_s[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  rd_data_s = minstret_s[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_data_s = minstret_s[63:32];
`endif
      default: begin
        rd_data_s     = {XLEN{1'b0}};
        implemented_s = 1'b0;
      end
    endcase
    // Set/clear with x0/zimm=0 is a pure read
    write_req_s = (req_op_r == OP_RW) | (req_field_r != 5'd0);
    illegal_s   = (req_op_r == OP_NONE) | ~implemented_s |
                  ((req_addr_r[11:10] == 2'b11) & write_req_s);
    new_s       = csr_apply_op(req_op_r, rd_data_s, req_operand_r);
  end

  // Request FSM, trap entry, response registers and CSR state
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      busy          <= 1'b0;
      req_op_r      <= 2'b00;
      req_addr_r    <= 12'h000;
      req_operand_r <= {XLEN{1'b0}};
      req_field_r   <= 5'd0;
      new_r         <= {XLEN{1'b0}};
      wen_r         <= 1'b0;
      pipe_rd_valid <= 1'b0;
      pipe_rd       <= {XLEN{1'b0}};
      pipe_illegal  <= 1'b0;
      mie_r         <= 1'b0;
      mpie_r        <= 1'b0;
      mtvec_r       <= MTVEC_RESET;
      mscratch_r    <= {XLEN{1'b0}};
      mepc_r        <= {XLEN{1'b0}};
      mcause_r      <= {XLEN{1'b0}};
    end else begin
      pipe_rd_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (trap_req_valid) begin
            mepc_r   <= {trap_mepc[XLEN-1:2], 2'b00};
            mcause_r <= trap_mcause;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
          end else if (pipe_req_valid) begin
            req_op_r      <= pipe_funct3[1:0];
            req_addr_r    <= pipe_csr_addr;
            req_field_r   <= pipe_rs1_field;
            req_operand_r <= pipe_funct3[2] ? {{(XLEN-5){1'b0}}, pipe_rs1_field}
                                            : pipe_rs1;
            state_r       <= ST_READ;
            busy          <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          pipe_rd       <= illegal_s ? {XLEN{1'b0}} : rd_data_s;
          pipe_illegal  <= illegal_s;
          new_r         <= new_s;
          wen_r         <= ~illegal_s & write_req_s;
          pipe_rd_valid <= 1'b1;
          state_r       <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (wen_r) begin
            case (req_addr_r)
              ADDR_MSTATUS: begin
                mie_r  <= new_r[MSTATUS_MIE];
                mpie_r <= new_r[MSTATUS_MPIE];
              end
              ADDR_MTVEC:    mtvec_r    <= {new_r[XLEN-1:2], 2'b00};
              ADDR_MSCRATCH: mscratch_r <= new_r;
              ADDR_MEPC:     mepc_r     <= {new_r[XLEN-1:2], 2'b00};
              ADDR_MCAUSE:   mcause_r   <= new_r;
              default:       mcause_r   <= mcause_r;
            endcase
          end
          wen_r   <= 1'b0;
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_controller.sv
// Self-checking bench for csr_access_controller. Expected responses are
// queued when a request is accepted and checked by a monitor on each strobe.
module tb_csr_access_controller;

  localparam logic [31:0] TB_MTVEC = 32'h8000_0100;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_req_valid = 1'b0;
  logic        pipe_req_ready;
  logic [2:0]  pipe_funct3 = 3'b000;
  logic [11:0] pipe_csr_addr = 12'h000;
  logic [31:0] pipe_rs1 = 32'h0;
  logic [4:0]  pipe_rs1_field = 5'd0;
  logic        pipe_rd_valid;
  logic [31:0] pipe_rd;
  logic        pipe_illegal;
  logic        trap_req_valid = 1'b0;
  logic        trap_req_ready;
  logic [31:0] trap_mepc = 32'h0;
  logic [31:0] trap_mcause = 32'h0;
  logic        retire = 1'b0;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_out;
  logic        busy;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [63:0] mcyc_m;

  csr_access_controller #(.XLEN(32), .MTVEC_RESET(TB_MTVEC)) dut (
    .CLK(CLK), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_ready(pipe_req_ready),
    .pipe_funct3(pipe_funct3), .pipe_csr_addr(pipe_csr_addr),
    .pipe_rs1(pipe_rs1), .pipe_rs1_field(pipe_rs1_field),
    .pipe_rd_valid(pipe_rd_valid), .pipe_rd(pipe_rd), .pipe_illegal(pipe_illegal),
    .trap_req_valid(trap_req_valid), .trap_req_ready(trap_req_ready),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .retire(retire),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference mcycle: counts every cycle out of reset
  always @(posedge CLK or posedge reset) begin
    if (reset) mcyc_m <= 64'd0;
    else       mcyc_m <= mcyc_m + 64'd1;
  end

  // Scoreboard monitor: every strobe must match the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    if (!reset && pipe_rd_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_strobe cycle=%0d rd=%h", cyc, pipe_rd);
      end else begin
        e = sb_q.pop_front();
        n_vec += 3;
        if (pipe_rd !== e.rd) begin
          n_err++; $display("FAIL rd_data got=%h exp=%h", pipe_rd, e.rd);
        end
        if (pipe_illegal !== e.ill) begin
          n_err++; $display("FAIL illegal got=%b exp=%b", pipe_illegal, e.ill);
        end
        if (cyc !== e.due) begin
          n_err++; $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, e.due);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] field);
    @(negedge CLK);
    pipe_funct3 = f3; pipe_csr_addr = addr; pipe_rs1 = rs1; pipe_rs1_field = field;
    pipe_req_valid = 1'b1;
  endtask

  task automatic accept(input logic [31:0] exp_rd, input logic exp_ill);
    int   w = 0;
    int   acc;
    exp_t e;
    while (!pipe_req_ready && w < 20) begin @(negedge CLK); w++; end
    acc = cyc;
    @(posedge CLK); #1;
    e.rd = exp_rd; e.ill = exp_ill; e.due = acc + 2;
    sb_q.push_back(e);
  endtask

  task automatic scramble;
    pipe_req_valid = 1'b0;
    pipe_funct3    = 3'($urandom);
    pipe_csr_addr  = 12'($urandom);
    pipe_rs1       = $urandom;
    pipe_rs1_field = 5'($urandom);
  endtask

  task automatic drain;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL response_timeout pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] field,
                       input logic [31:0] exp_rd, input logic exp_ill);
    drive(f3, addr, rs1, field);
    accept(exp_rd, exp_ill);
    scramble();
    drain();
  endtask

  task automatic test_reset;
    n_vec += 6;
    if (mtvec_out !== TB_MTVEC) begin n_err++; $display("FAIL reset_mtvec got=%h exp=%h", mtvec_out, TB_MTVEC); end
    if (mepc_out !== 32'h0) begin n_err++; $display("FAIL reset_mepc got=%h exp=0", mepc_out); end
    if (mie_out !== 1'b0) begin n_err++; $display("FAIL reset_mie got=%b exp=0", mie_out); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (pipe_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", pipe_rd_valid); end
    if (pipe_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", pipe_req_ready); end
  endtask

  task automatic test_rw_rs;
    do_op(3'b001, 12'h340, 32'hDEADBEEF, 5'd5,  32'h0,        1'b0);
    do_op(3'b010, 12'h340, 32'hFFFFFFFF, 5'd0,  32'hDEADBEEF, 1'b0);
    do_op(3'b010, 12'h340, 32'hFFFFFFFF, 5'd0,  32'hDEADBEEF, 1'b0);
    do_op(3'b011, 12'h340, 32'h0000FFFF, 5'd3,  32'hDEADBEEF, 1'b0);
    do_op(3'b110, 12'h340, 32'hFFFFFFFF, 5'h1F, 32'hDEAD0000, 1'b0);
    do_op(3'b101, 12'h340, 32'hFFFFFFFF, 5'd0,  32'hDEAD001F, 1'b0);
    do_op(3'b010, 12'h340, 32'h0,        5'd0,  32'h0,        1'b0);
  endtask

  task automatic test_mie;
    do_op(3'b110, 12'h300, 32'h0, 5'd8, 32'h0, 1'b0);
    n_vec++;
    if (mie_out !== 1'b1) begin n_err++; $display("FAIL mie_set got=%b exp=1", mie_out); end
    do_op(3'b010, 12'h300, 32'h0, 5'd0, 32'h8, 1'b0);
    do_op(3'b111, 12'h300, 32'h0, 5'd8, 32'h8, 1'b0);
    n_vec++;
    if (mie_out !== 1'b0) begin n_err++; $display("FAIL mie_clear got=%b exp=0", mie_out); end
    do_op(3'b001, 12'h300, 32'hFFFFFFFF, 5'd1, 32'h0,  1'b0);
    do_op(3'b001, 12'h300, 32'h0,        5'd1, 32'h88, 1'b0);
  endtask

  task automatic test_trap;
    do_op(3'b110, 12'h300, 32'h0, 5'd8, 32'h0, 1'b0);
    @(negedge CLK);
    trap_req_valid = 1'b1; trap_mepc = 32'h1003; trap_mcause = 32'h2;
    pipe_funct3 = 3'b010; pipe_csr_addr = 12'h341; pipe_rs1 = 32'hFFFF; pipe_rs1_field = 5'd0;
    pipe_req_valid = 1'b1;
    #1;
    n_vec += 2;
    if (trap_req_ready !== 1'b1) begin n_err++; $display("FAIL trap_ready got=%b exp=1", trap_req_ready); end
    if (pipe_req_ready !== 1'b0) begin n_err++; $display("FAIL pipe_blocked got=%b exp=0", pipe_req_ready); end
    @(posedge CLK); #1;
    trap_req_valid = 1'b0; trap_mepc = $urandom; trap_mcause = $urandom;
    @(negedge CLK);
    n_vec += 4;
    if (mepc_out !== 32'h1000) begin n_err++; $display("FAIL trap_mepc got=%h exp=1000", mepc_out); end
    if (mie_out !== 1'b0) begin n_err++; $display("FAIL trap_mie got=%b exp=0", mie_out); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL trap_busy got=%b exp=0", busy); end
    if (pipe_req_ready !== 1'b1) begin n_err++; $display("FAIL pipe_after_trap got=%b exp=1", pipe_req_ready); end
    accept(32'h1000, 1'b0);
    scramble();
    drain();
    do_op(3'b010, 12'h300, 32'h0, 5'd0, 32'h80, 1'b0);
    do_op(3'b010, 12'h342, 32'h0, 5'd0, 32'h2,  1'b0);
    do_op(3'b001, 12'h341, 32'h2003, 5'd2, 32'h1000, 1'b0);
    n_vec++;
    if (mepc_out !== 32'h2000) begin n_err++; $display("FAIL mepc_align got=%h exp=2000", mepc_out); end
  endtask

  task automatic test_illegal;
    do_op(3'b001, 12'h340, 32'h5A5A5A5A, 5'd1, 32'h0, 1'b0);
    do_op(3'b001, 12'h7C0, 32'h1,        5'd1, 32'h0, 1'b1);
    do_op(3'b100, 12'h340, 32'h1,        5'd7, 32'h0, 1'b1);
    do_op(3'b000, 12'h340, 32'h1,        5'd7, 32'h0, 1'b1);
    do_op(3'b001, 12'hF11, 32'h1,        5'd1, 32'h0, 1'b1);
`ifndef CSR_COUNTERS_EN
    do_op(3'b010, 12'hC00, 32'h0,        5'd0, 32'h0, 1'b1);
    do_op(3'b001, 12'hB00, 32'h1,        5'd1, 32'h0, 1'b1);
`endif
    do_op(3'b010, 12'h340, 32'h0,        5'd0, 32'h5A5A5A5A, 1'b0);
    do_op(3'b001, 12'h305, 32'h12345677, 5'd1, TB_MTVEC, 1'b0);
    n_vec++;
    if (mtvec_out !== 32'h12345674) begin n_err++; $display("FAIL mtvec_align got=%h exp=12345674", mtvec_out); end
  endtask

  task automatic test_back_to_back;
    int w = 0;
    drive(3'b001, 12'h340, 32'h11111111, 5'd1);
    accept(32'h5A5A5A5A, 1'b0);
    pipe_rs1 = 32'h22222222;
    @(negedge CLK);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_read got=%b exp=1", busy); end
    w = 1;
    while (!pipe_req_ready && w < 10) begin @(negedge CLK); w++; end
    n_vec++;
    if (w !== 3) begin n_err++; $display("FAIL throughput got=%0d exp=3", w); end
    accept(32'h11111111, 1'b0);
    scramble();
    drain();
    do_op(3'b010, 12'h340, 32'h0, 5'd0, 32'h22222222, 1'b0);
  endtask

  task automatic test_reset_mid;
    drive(3'b001, 12'h340, 32'h1, 5'd1);
    @(posedge CLK); #1;
    scramble();
    @(negedge CLK);
    reset = 1'b1;
    #1;
    n_vec += 5;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (pipe_rd_valid !== 1'b0) begin n_err++; $display("FAIL abort_strobe got=%b exp=0", pipe_rd_valid); end
    if (mtvec_out !== TB_MTVEC) begin n_err++; $display("FAIL abort_mtvec got=%h exp=%h", mtvec_out, TB_MTVEC); end
    if (mepc_out !== 32'h0) begin n_err++; $display("FAIL abort_mepc got=%h exp=0", mepc_out); end
    if (mie_out !== 1'b0) begin n_err++; $display("FAIL abort_mie got=%b exp=0", mie_out); end
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    do_op(3'b010, 12'h340, 32'h0, 5'd0, 32'h0, 1'b0);
    do_op(3'b010, 12'h300, 32'h0, 5'd0, 32'h0, 1'b0);
    do_op(3'b010, 12'h342, 32'h0, 5'd0, 32'h0, 1'b0);
    do_op(3'b010, 12'h341, 32'h0, 5'd0, 32'h0, 1'b0);
    do_op(3'b010, 12'h305, 32'h0, 5'd0, TB_MTVEC, 1'b0);
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters;
    repeat (10) @(negedge CLK);
    repeat (3) begin
      @(negedge CLK); retire = 1'b1;
      @(negedge CLK); retire = 1'b0;
    end
    drive(3'b010, 12'hB00, 32'h0, 5'd0);
    begin
      int   acc;
      exp_t e;
      acc = cyc;
      @(posedge CLK); #1;
      e.rd = mcyc_m[31:0]; e.ill = 1'b0; e.due = acc + 2;
      sb_q.push_back(e);
    end
    scramble();
    drain();
    do_op(3'b010, 12'hB02, 32'h0,        5'd0, 32'h3,   1'b0);
    do_op(3'b010, 12'hC02, 32'h0,        5'd0, 32'h3,   1'b0);
    do_op(3'b001, 12'hC00, 32'h1,        5'd1, 32'h0,   1'b1);
    do_op(3'b010, 12'hC00, 32'hFF,       5'd4, 32'h0,   1'b1);
    do_op(3'b001, 12'hB02, 32'd100,      5'd1, 32'h3,   1'b0);
    do_op(3'b010, 12'hB02, 32'h0,        5'd0, 32'd100, 1'b0);
    do_op(3'b001, 12'hB82, 32'hFFFFFFFF, 5'd1, 32'h0,   1'b0);
    do_op(3'b001, 12'hB02, 32'hFFFFFFFF, 5'd1, 32'd100, 1'b0);
    @(negedge CLK); retire = 1'b1;
    @(negedge CLK); retire = 1'b0;
    do_op(3'b010, 12'hB02, 32'h0, 5'd0, 32'h0, 1'b0);
    do_op(3'b010, 12'hB82, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    test_reset();
    reset = 1'b0;
    test_rw_rs();
    test_mie();
    test_trap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
`ifdef CSR_COUNTERS_EN
    test_counters();
`endif
    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_access_controller.md
Name: csr_access_controller

Overview:
Sequences Zicsr read-modify-write operations onto a small machine-mode CSR set, and owns the architectural state of that set. Arbitrates between two requesters: the pipeline (CSRRW/RS/RC and the immediate forms) and the trap unit (mepc/mcause/mstatus update on exception entry). Sits beside the execute stage. Exports mtvec/mepc/MIE to fetch and trap logic.

Parameters:
XLEN, 32, data width of CSRs and operands (only 32 supported)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
CLK  in  1  clock (rising edge)
reset  in  1  asynchronous, active-high reset
pipe_req_valid  in  1  pipeline CSR request
pipe_req_ready  out  1  request accepted when valid&ready
pipe_funct3  in  3  Zicsr funct3
pipe_csr_addr  in  12  CSR address
pipe_rs1  in  XLEN  rs1 register value
pipe_rs1_field  in  5  instruction bits [19:15] (rs1 index or zimm)
pipe_rd_valid  out  1  one-cycle response strobe
pipe_rd  out  XLEN  old CSR value
pipe_illegal  out  1  qualified by pipe_rd_valid
trap_req_valid  in  1  trap-entry request
trap_req_ready  out  1  trap accepted when valid&ready
trap_mepc  in  XLEN  faulting PC
trap_mcause  in  XLEN  cause code
retire  in  1  one instruction retired this cycle
mtvec_out  out  XLEN  current mtvec
mepc_out  out  XLEN  current mepc
mie_out  out  1  mstatus.MIE
busy  out  1  state != IDLE

Behaviour:
- Implemented CSRs: mstatus 0x300 (only MIE bit3, MPIE bit7 writable, others read 0); mtvec 0x305 (bits[1:0] forced 0); mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342.
- Reset: all outputs 0 except mtvec_out=MTVEC_RESET; all CSRs 0; state IDLE. Reset mid-operation aborts the request; no pipe_rd_valid is issued.
- FSM: IDLE -> READ -> COMMIT -> IDLE.
  - IDLE: accepts a request.
  - READ: latches the old value and computes the new value.
  - COMMIT: writes the CSR and pulses pipe_rd_valid for exactly 1 cycle.
  - Latency: accept at cycle N, pipe_rd_valid at N+2. Throughput is 1 op per 3 cycles.
- Operand: funct3[2]=1 uses {27'b0, pipe_rs1_field}; otherwise pipe_rs1.
- Op selection by funct3[1:0]:
  - 01: new = operand.
  - 10: new = old | operand.
  - 11: new = old & ~operand.
- Write suppression: RS/RC forms with pipe_rs1_field==0 perform no write. The read still occurs.
- Illegal cases, all of which give pipe_illegal=1, pipe_rd=0, no write, same N+2 timing:
  - funct3 000 or 100;
  - unimplemented address;
  - write to a read-only address (addr[11:10]==2'b11) that is not suppressed.
- Arbitration: trap has priority.
  - trap_req_ready = (state==IDLE).
  - pipe_req_ready = (state==IDLE) & ~trap_req_valid.
- Trap entry is single-cycle in IDLE: mepc<=trap_mepc&~3, mcause<=trap_mcause, MPIE<=MIE, MIE<=0. No response strobe.
- Inputs are sampled only on the accept edge. Later changes to the inputs are ignored.

Optional Feature:
CSR_COUNTERS_EN:
- When defined, adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus read-only aliases cycle 0xC00/0xC80 and instret 0xC02/0xC82.
- mcycle increments every cycle; minstret increments when retire=1. Both wrap from 2^64-1 to 0.
- A COMMIT write to a half replaces that half. The increment is dropped in that cycle for that counter.
- When undefined, these addresses are illegal and no counter flops exist.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants;
  - funct3 encodings;
  - FSM state enum;
  - mstatus bit positions (MIE=3, MPIE=7).
- Sub-module csr_counter64: 64-bit counter with increment enable and low/high half-write ports. It is instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- CSRRW 0x340, rs1=0xDEADBEEF after reset -> pipe_rd_valid at N+2, pipe_rd=0; a following CSRRS, rs1_field=0 -> pipe_rd=0xDEADBEEF, no write.
- CSRRSI 0x300, zimm=8 then CSRRCI zimm=8 -> mie_out 0->1 at the first COMMIT, then 1->0; mstatus reads 0x8 between the two.
- trap_req_valid and pipe_req_valid asserted in the same IDLE cycle, with mepc=0x1003, mcause=2 -> trap accepted first; mepc_out=0x1000, MIE=0, MPIE=old MIE; pipe accepted the next cycle.
- CSRRW to 0x7C0 and funct3=100 -> pipe_illegal=1, pipe_rd=0, no CSR changes.
- Counters build: idle 10 cycles, retire pulsed 3 times -> mcycle ≈ 10 + read latency, minstret=3; CSRRW 0xC00 -> illegal; CSRRS 0xC00 with rs1_field=0 -> legal read.
- Assert reset during the READ state -> busy=0 immediately, no pipe_rd_valid, all CSRs 0.
